load_store_unit: RTL and testbench

Data-memory access stage that executes load/store instructions and produces the 32-bit load result consumed by the writeback output select (its `Mem_ReadData` input). It accepts one access from control, performs a valid/ready request and read-response handshake with data memory, generates byte strobes for stores, and extracts plus sign- or zero-extends bytes and halfwords for loads. One access is in flight at a time. A `done` pulse marks each completion.

---
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store stage: valid/ready request plus read-response handshake to data memory,
// store byte strobes, load lane extraction/extension. Optional: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DONE} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] wait_cnt;

  logic        req_bad;
  logic [3:0]  req_strb;
  logic [31:0] req_wd;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic        timed_out;

  assign req_ready = (state == IDLE);
  assign mem_valid = (state == ISSUE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_bad  = 1'b0;
    req_strb = 4'b1111;
    req_wd   = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: begin
        req_strb = 4'b0001 << req_addr[1:0];
        req_wd   = {4{req_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        req_strb = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wd   = {2{req_wdata[15:0]}};
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad  = req_addr[0];
`endif
      end
      3'b010: begin
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad  = |req_addr[1:0];
`endif
      end
      default: req_bad = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (req_we && req_funct3[2]) req_bad = 1'b1;
    if (!req_we) req_strb = 4'b0000;
  end

  // Misaligned halfword/word accesses fall onto the aligned lane because only
  // off_q[1] selects the half and words ignore the offset entirely.
  always_comb begin
    rd_byte = 8'(mem_rdata >> {off_q, 3'b000});
    rd_half = 16'(mem_rdata >> {off_q[1], 4'b0000});
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_ext = {24'h000000, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  rd_ext = {16'h0000, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  // wait_cnt holds the number of waiting cycles already spent, so the current one is wait_cnt+1.
  assign timed_out = ({1'b0, wait_cnt} + 17'd1) >= 17'(TIMEOUT_CYCLES);

  // NOTE: state and registered outputs use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      load_data <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      wait_cnt  <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= ISSUE;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= req_strb;
              mem_wdata <= req_wd;
              f3_q      <= req_funct3;
              off_q     <= req_addr[1:0];
              wait_cnt  <= '0;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= wait_cnt + 16'd1;
          if (mem_ready && mem_we) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (timed_out) begin
            state <= DONE;
            done  <= 1'b1;
            fault <= 1'b1;
          end else if (mem_ready) begin
            state <= WAIT_R;
          end
        end
        WAIT_R: begin
          wait_cnt <= wait_cnt + 16'd1;
          if (mem_rvalid) begin
            load_data <= rd_ext;
            state     <= DONE;
            done      <= 1'b1;
          end else if (timed_out) begin
            state <= DONE;
            done  <= 1'b1;
            fault <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: transaction-level timeline model plus
// a per-cycle compare process; directed cases pin the model with literal values.
module tb_load_store_unit;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] load_data;
  logic        done;
  logic        fault;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .load_data(load_data), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs for the current cycle, set just after each rising edge.
  bit          chk_en = 1'b0;
  bit          exp_ready, exp_mval, exp_done, exp_fault, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_strb;
  logic [31:0] ld_model = '0;

  // Observations gathered by the compare process.
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_strb;
  int          n_issue = 0;
  int          n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      check("mem_valid", {31'b0, mem_valid}, {31'b0, exp_mval});
      check("done", {31'b0, done}, {31'b0, exp_done});
      check("fault", {31'b0, fault}, {31'b0, exp_fault});
      check("load_data", load_data, exp_ld);
      if (exp_mval) begin
        check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_strb});
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
    end
    if (mem_valid) begin
      obs_addr  = mem_addr;
      obs_strb  = mem_wstrb;
      obs_wdata = mem_wdata;
      n_issue++;
    end
    if (done) n_done++;
  end

  function automatic bit is_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2) != 0) return 1'b1;
    if (f3 == 3'd2 && (addr % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] strb_of(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd0) return 4'(1 << (addr % 4));
    if (f3 == 3'd1) return 4'(3 << (addr & 32'd2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] wdata);
    if (f3 == 3'd0) return (wdata & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (wdata & 32'hFFFF) * 32'h0001_0001;
    return wdata;
  endfunction

  // Sign extension done arithmetically: subtracting 2^n from a value with its top bit set.
  function automatic logic [31:0] load_of(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (rdata >> ((addr % 4) * 8)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (rdata >> ((addr & 32'd2) * 8)) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic set_exp(input bit rdy, input bit mv, input bit dn, input bit ft);
    exp_ready = rdy;
    exp_mval  = mv;
    exp_done  = dn;
    exp_fault = ft;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access. Memory accepts in waiting cycle rdy_dly+1; for loads the response
  // comes rv_dly+1 cycles later. Waiting cycles are numbered from 1 after accept.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int rdy_dly, input int rv_dly,
                        input logic [31:0] rdata);
    bit bad, flt;
    int needed, done_cyc, issue_last;
    bad       = is_bad(we, f3, addr);
    exp_we    = we;
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_strb  = we ? strb_of(f3, addr) : 4'h0;
    exp_wdata = wdata_of(f3, wdata);
    exp_ld    = ld_model;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (bad) begin
      flt = 1'b1; done_cyc = 1;
    end else begin
      needed   = we ? rdy_dly + 1 : rdy_dly + rv_dly + 2;
      flt      = needed > T;
      done_cyc = (flt ? T : needed) + 1;
    end
    issue_last = (rdy_dly + 1 < T) ? rdy_dly + 1 : T;
    for (int c = 1; c <= done_cyc; c++) begin
      if (c < done_cyc) begin
        set_exp(1'b0, !bad && c <= issue_last, 1'b0, 1'b0);
        mem_ready = (c == rdy_dly + 1);
        if (c <= rdy_dly + 1) begin
          mem_rvalid = $urandom_range(0, 1);
          mem_rdata  = $urandom;
        end else begin
          mem_rvalid = (c == rdy_dly + rv_dly + 2);
          mem_rdata  = mem_rvalid ? rdata : $urandom;
        end
      end else begin
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        if (!flt && !we) ld_model = load_of(f3, addr, rdata);
        exp_ld = ld_model;
        set_exp(1'b0, 1'b0, 1'b1, flt);
      end
      next_cycle();
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int i0, d0;
    logic [2:0] f3;
    logic we;
    int rdy, rv;
    logic [2:0] ld_f3 [5];
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_done_fault", {30'b0, done, fault}, 32'd0);
    reset = 1'b0;
    exp_ld = '0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;

    // Store byte to the top lane.
    i0 = n_issue;
    access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0);
    check("sb_addr", obs_addr, 32'h0000_1000);
    check("sb_strb", {28'b0, obs_strb}, 32'h0000_0008);
    check("sb_wdata", obs_wdata, 32'hABAB_ABAB);
    check("sb_issue_cycles", n_issue - i0, 32'd1);

    access(1'b0, 3'b000, 32'h0000_2002, 32'h0, 0, 0, 32'h12F0_3456);
    check("lb_value", load_data, 32'hFFFF_FFF0);
    access(1'b0, 3'b100, 32'h0000_2002, 32'h0, 0, 0, 32'h12F0_3456);
    check("lbu_value", load_data, 32'h0000_00F0);

    d0 = n_done;
    i0 = n_issue;
    access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 3, 2, 32'h8001_FFFF);
    check("lhu_value", load_data, 32'h0000_8001);
    check("lhu_done_once", n_done - d0, 32'd1);
    check("lhu_issue_cycles", n_issue - i0, 32'd4);

    // Response never arrives: times out after T waiting cycles.
    access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 0, 1000, 32'h0);
    check("timeout_keeps_ld", load_data, 32'h0000_8001);

    i0 = n_issue;
    access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 0, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_no_issue", n_issue - i0, 32'd0);
`else
    check("lw_mis_addr", obs_addr, 32'h0000_3000);
    check("lw_mis_value", load_data, 32'hCAFE_F00D);
`endif

    // Reset in WAIT_R, then reset together with a request, while a stale response arrives.
    d0 = n_done;
    i0 = n_issue;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_5000;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    req_valid = 1'b0; mem_ready = 1'b1;
    exp_we = 1'b0; exp_addr = 32'h0000_5000; exp_strb = 4'h0;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    mem_ready = 1'b0; reset = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    req_valid = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    ld_model = '0; exp_ld = '0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_mid_addr", mem_addr, 32'd0);
    next_cycle();
    reset = 1'b0; req_valid = 1'b0;
    next_cycle();
    mem_rvalid = 1'b0;
    next_cycle();
    check("rst_mid_no_done", n_done - d0, 32'd0);
    check("rst_mid_ld", load_data, 32'd0);
    check("rst_mid_issues", n_issue - i0, 32'd1);

    // Randomized traffic, mostly legal with occasional illegal funct3 and long latencies.
    for (int n = 0; n < 300; n++) begin
      we = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 8) f3 = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom);
      rdy = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 4);
      rv  = $urandom_range(0, 3);
      access(we, f3, $urandom, $urandom, rdy, rv, $urandom);
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
